// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter putting an instruction-fetch port and a load/store port onto
// one single-ported RAM; each access takes IDLE -> ACCESS -> CAPTURE (3 cycles).
`timescale 1ns/1ps
module ram_port_arbiter #(
  parameter int         ADDR_W       = 16,
  parameter int         DATA_W       = 16,
  parameter int         MEM_WORDS    = 1024,
  parameter logic [2:0] ACCESS_STATE = 3'b011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic [1:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic [1:0]        ram_mem_op,
  output logic [2:0]        ram_state,
  input  logic [DATA_W-1:0] ram_read_data
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [ADDR_W:0] MEM_LIMIT = MEM_WORDS[ADDR_W:0];

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg;  // 1 = data port won last
  logic              owner_reg;       // 1 = data port owns the access in flight
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [2:0]        ram_state_reg, ram_state_next;
  logic [1:0]        ram_mem_op_reg, ram_mem_op_next;
  logic [1:0]        gnt_next, done_next;

  logic              any_req, accept, win_data;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_op;
  logic              win_in_range, win_op_valid, cur_in_range, rd_load;

  // On a tie the port that did not win last time goes first.
  assign any_req      = if_req | d_req;
  assign accept       = (state_reg == IDLE) && any_req;
  assign win_data     = d_req && (!if_req || !last_grant_reg);
  assign win_addr     = win_data ? d_addr : if_addr;
  assign win_op       = win_data ? d_op : OP_READ;
  assign win_in_range = ({1'b0, win_addr} < MEM_LIMIT);
  assign win_op_valid = (win_op == OP_READ) || (win_op == OP_WRITE);
  assign cur_in_range = ({1'b0, addr_reg} < MEM_LIMIT);
  assign rd_load      = (op_reg == OP_READ) && cur_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next        = 2'b00;
    done_next       = 2'b00;
    ram_state_next  = 3'b000;
    ram_mem_op_next = OP_NOP;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_next[win_data] = 1'b1;
          ram_state_next     = ACCESS_STATE;
          if (win_op_valid && win_in_range) ram_mem_op_next = win_op;
        end
      end
      CAPTURE: done_next[owner_reg] = 1'b1;
      default: ;
    endcase
  end

  // Address and write data stay latched between accesses and feed the RAM directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      op_reg         <= OP_NOP;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ram_state_reg  <= 3'b000;
      ram_mem_op_reg <= OP_NOP;
    end else begin
      ram_state_reg  <= ram_state_next;
      ram_mem_op_reg <= ram_mem_op_next;
      if (accept) begin
        last_grant_reg <= win_data;
        owner_reg      <= win_data;
        op_reg         <= win_op;
        addr_reg       <= win_addr;
        if (win_data) wdata_reg <= d_wdata;
      end
    end
  end

  assign ram_address    = addr_reg;
  assign ram_write_data = wdata_reg;
  assign ram_state      = ram_state_reg;
  assign ram_mem_op     = ram_mem_op_reg;

  // Port 0 is fetch, port 1 is data; each keeps its own handshake and read-data registers.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              gnt_reg, done_reg, err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          gnt_reg   <= 1'b0;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          gnt_reg  <= gnt_next[gi];
          done_reg <= done_next[gi];
          err_reg  <= done_next[gi] & ~cur_in_range;
          if (done_next[gi] && rd_load) rdata_reg <= ram_read_data;
        end
      end

      if (gi == 0) begin : g_fetch
        assign if_gnt   = gnt_reg;
        assign if_done  = done_reg;
        assign if_err   = err_reg;
        assign if_rdata = rdata_reg;
      end else begin : g_data
        assign d_gnt   = gnt_reg;
        assign d_done  = done_reg;
        assign d_err   = err_reg;
        assign d_rdata = rdata_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences for contention and
// reset mid-access, then random two-port traffic checked against a transaction model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic if_gnt, if_done, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic d_req = 1'b0;
  logic [1:0] d_op = 2'b00;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic d_gnt, d_done, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data;
  logic [1:0] ram_mem_op;
  logic [2:0] ram_state;
  logic [DATA_W-1:0] ram_read_data = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .ACCESS_STATE(3'b011)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_mem_op(ram_mem_op), .ram_state(ram_state), .ram_read_data(ram_read_data)
  );

  // 1024-word synchronous RAM; like the real part it decodes only the low 10 address bits.
  logic [15:0] ram_mem [MEM_WORDS] = '{default: '0};
  logic pl_en = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram_mem[pl_addr] <= pl_data;
    else if (ram_state == 3'b011) begin
      if (ram_mem_op == 2'b10) ram_mem[ram_address[9:0]] <= ram_write_data;
      if (ram_mem_op == 2'b01) ram_read_data <= ram_mem[ram_address[9:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  typedef struct packed {
    logic        port;      // 0 fetch, 1 data
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  exp_op;    // expected ram_mem_op in the ACCESS cycle
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic run_single(input vec_t v, input int idx);
    logic [1:0] onehot;
    onehot = v.port ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    if (v.port) begin
      d_req = 1'b1; d_op = v.op; d_addr = v.addr; d_wdata = v.wdata;
      if_addr = 16'($urandom);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      d_op = 2'b10; d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    @(negedge clk);
    chk($sformatf("v%0d idle gnt", idx), 32'({d_gnt, if_gnt}), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d gnt", idx), 32'({d_gnt, if_gnt}), 32'(onehot));
    chk($sformatf("v%0d ram_state", idx), 32'(ram_state), 32'(3'b011));
    chk($sformatf("v%0d ram_mem_op", idx), 32'(ram_mem_op), 32'(v.exp_op));
    chk($sformatf("v%0d ram_address", idx), 32'(ram_address), 32'(v.addr));
    if (v.exp_op == 2'b10) chk($sformatf("v%0d ram_write_data", idx), 32'(ram_write_data), 32'(v.wdata));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_op = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d capture done", idx), 32'({d_done, if_done}), 32'(0));
    chk($sformatf("v%0d capture ram_state", idx), 32'(ram_state), 32'(0));
    chk($sformatf("v%0d capture ram_mem_op", idx), 32'(ram_mem_op), 32'(0));
    @(negedge clk);
    chk($sformatf("v%0d done", idx), 32'({d_done, if_done}), 32'(onehot));
    chk($sformatf("v%0d rdata", idx), 32'(v.port ? d_rdata : if_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d err", idx), 32'(v.port ? d_err : if_err), 32'(v.exp_err));
    $display("vec %0d: port=%0d op=%b addr=%h -> rdata=%h err=%0d",
             idx, v.port, v.op, v.addr, v.port ? d_rdata : if_rdata, v.port ? d_err : if_err);
  endtask

  // Random-phase requester state and transaction-level model.
  logic        pend [2];
  logic [1:0]  t_op [2];
  logic [15:0] t_addr [2];
  logic [15:0] t_wdata [2];
  int          age [2];
  logic [15:0] model_mem [MEM_WORDS] = '{default: '0};
  logic [15:0] exp_rdata [2];

  initial begin
    logic [1:0] exp_gnt, exp_done, exp_op, prev_req, cur_req;
    logic win, last_win, in_r, sb_valid, sb_port, sb_err;
    logic [15:0] sb_rdata, a, sb_addr;
    int free_at, sb_due, r;

    vecs[0]  = '{1'b0, 2'b01, 16'd5,    16'h0000, 2'b01, 16'hBEEF, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 16'd12,   16'h1234, 2'b10, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 2'b01, 16'd12,   16'h0000, 2'b01, 16'h1234, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 16'd1024, 16'hDEAD, 2'b00, 16'h1234, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 16'd0,    16'h0000, 2'b01, 16'hA5A5, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 16'd1023, 16'h0000, 2'b01, 16'h7777, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 16'd1024, 16'h0000, 2'b00, 16'h7777, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 16'd5,    16'hFFFF, 2'b00, 16'hA5A5, 1'b0};
    vecs[8]  = '{1'b1, 2'b11, 16'd5,    16'hFFFF, 2'b00, 16'hA5A5, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 16'd12,   16'h0000, 2'b01, 16'h1234, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 16'd1023, 16'h0F0F, 2'b10, 16'hA5A5, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 16'd1023, 16'h0000, 2'b01, 16'h0F0F, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset handshake", 32'({if_gnt, if_done, if_err, d_gnt, d_done, d_err}), 32'(0));
    chk("reset if_rdata", 32'(if_rdata), 32'(0));
    chk("reset d_rdata", 32'(d_rdata), 32'(0));
    chk("reset ram_state", 32'(ram_state), 32'(0));
    chk("reset ram_mem_op", 32'(ram_mem_op), 32'(0));
    chk("reset ram_address", 32'(ram_address), 32'(0));

    preload(10'd5, 16'hBEEF);
    preload(10'd0, 16'hA5A5);
    preload(10'd1023, 16'h7777);

    for (int i = 0; i < 12; i++) run_single(vecs[i], i);

    // Both ports held from reset: fetch, data, fetch, data, one grant per 3 cycles.
    @(posedge clk); #1;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'd5;
    d_req = 1'b1; d_op = 2'b01; d_addr = 16'd12;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      exp_gnt  = (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_done = (k % 3 == 0 && k > 0) ? ((((k - 3) / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("cont c%0d gnt", k), 32'({d_gnt, if_gnt}), 32'(exp_gnt));
      chk($sformatf("cont c%0d done", k), 32'({d_done, if_done}), 32'(exp_done));
      chk($sformatf("cont c%0d ram_state", k), 32'(ram_state), 32'((exp_gnt != 0) ? 3'b011 : 3'b000));
      if (exp_done == 2'b01) begin
        chk($sformatf("cont c%0d if_rdata", k), 32'(if_rdata), 32'(16'hBEEF));
        $display("contention cycle %0d: fetch done rdata=%h", k, if_rdata);
      end
      if (exp_done == 2'b10) begin
        chk($sformatf("cont c%0d d_rdata", k), 32'(d_rdata), 32'(16'h1234));
        $display("contention cycle %0d: data done rdata=%h", k, d_rdata);
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_op = 2'b00;
    repeat (2) @(posedge clk);

    // Reset during ACCESS abandons the access with no done.
    @(posedge clk); #1;
    d_req = 1'b1; d_op = 2'b01; d_addr = 16'd12;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst-mid gnt", 32'(d_gnt), 32'(1));
    chk("rst-mid ram_state", 32'(ram_state), 32'(3'b011));
    reset = 1'b1; d_req = 1'b0; d_op = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst-mid after ram_state", 32'(ram_state), 32'(0));
    chk("rst-mid after d_rdata", 32'(d_rdata), 32'(0));
    chk("rst-mid after gnt", 32'({d_gnt, if_gnt}), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst-mid no done %0d", k), 32'({d_done, if_done}), 32'(0));
      chk($sformatf("rst-mid idle ram_state %0d", k), 32'(ram_state), 32'(0));
    end
    $display("reset mid-access: abandoned, reissuing");
    run_single('{1'b1, 2'b01, 16'd12, 16'h0000, 2'b01, 16'h1234, 1'b0}, 100);

    // Random two-port traffic from a clean reset.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; age[p] = 0; exp_rdata[p] = 16'h0000;
      t_op[p] = 2'b01; t_addr[p] = '0; t_wdata[p] = '0;
    end
    prev_req = 2'b00; last_win = 1'b1; free_at = 0; sb_valid = 1'b0;
    sb_port = 1'b0; sb_err = 1'b0; sb_rdata = '0; sb_addr = '0; sb_due = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; age[p] = 0;
          r = int'($urandom_range(0, 9));
          t_addr[p] = (r < 7) ? 16'(256 + $urandom_range(0, 15))
                    : (r < 9) ? 16'(1024 + $urandom_range(0, 3)) : 16'hFFFF;
          r = int'($urandom_range(0, 9));
          t_op[p] = (p == 0) ? 2'b01 : (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
          t_wdata[p] = 16'($urandom);
        end
      end
      if_req = pend[0];
      if_addr = pend[0] ? t_addr[0] : 16'($urandom);
      d_req = pend[1];
      d_op = pend[1] ? t_op[1] : 2'($urandom);
      d_addr = pend[1] ? t_addr[1] : 16'($urandom);
      d_wdata = pend[1] ? t_wdata[1] : 16'($urandom);
      cur_req = {pend[1], pend[0]};
      @(negedge clk);
      exp_gnt = 2'b00; exp_op = 2'b00; a = '0;
      if (k - 1 >= free_at && prev_req != 2'b00) begin
        win = (prev_req == 2'b11) ? !last_win : prev_req[1];
        exp_gnt[win] = 1'b1;
        last_win = win;
        free_at = k + 2;
        a = t_addr[win];
        in_r = (a < 16'(MEM_WORDS));
        if (in_r && (t_op[win] == 2'b01 || t_op[win] == 2'b10)) exp_op = t_op[win];
        sb_rdata = exp_rdata[win];
        if (in_r && t_op[win] == 2'b10) model_mem[a[9:0]] = t_wdata[win];
        if (in_r && t_op[win] == 2'b01) sb_rdata = model_mem[a[9:0]];
        sb_valid = 1'b1; sb_due = k + 2; sb_port = win; sb_err = !in_r; sb_addr = a;
      end
      chk($sformatf("rnd c%0d gnt", k), 32'({d_gnt, if_gnt}), 32'(exp_gnt));
      chk($sformatf("rnd c%0d ram_state", k), 32'(ram_state), 32'((exp_gnt != 0) ? 3'b011 : 3'b000));
      chk($sformatf("rnd c%0d ram_mem_op", k), 32'(ram_mem_op), 32'(exp_op));
      if (exp_gnt != 2'b00) chk($sformatf("rnd c%0d ram_address", k), 32'(ram_address), 32'(a));
      if (if_gnt) pend[0] = 1'b0;
      if (d_gnt) pend[1] = 1'b0;
      exp_done = (sb_valid && sb_due == k) ? (sb_port ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rnd c%0d done", k), 32'({d_done, if_done}), 32'(exp_done));
      if (exp_done != 2'b00) begin
        exp_rdata[sb_port] = sb_rdata;
        chk($sformatf("rnd c%0d rdata", k), 32'(sb_port ? d_rdata : if_rdata), 32'(sb_rdata));
        chk($sformatf("rnd c%0d err", k), 32'(sb_port ? d_err : if_err), 32'(sb_err));
        $display("rnd cycle %0d: port=%0d addr=%h rdata=%h err=%0d",
                 k, sb_port, sb_addr, sb_port ? d_rdata : if_rdata, sb_port ? d_err : if_err);
        sb_valid = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          age[p]++;
          chk($sformatf("rnd c%0d port%0d wait bound", k, p), 32'(age[p] > 8), 32'(0));
        end
      end
      prev_req = cur_req;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
